// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory-access pipeline stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_signed;
  logic [4:0]  req_rd;
  logic        halt;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, req_signed, req_rd,
    input  halt, resp_valid, resp_rd, resp_data, err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, req_signed, req_rd,
    output halt, resp_valid, resp_rd, resp_data, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline, performs byte-lane stores
// and sign/zero-extended loads. Define DMEM_ALIGN_CHECK_EN to trap misaligned accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            we_r;
  logic [1:0]      size_r;
  logic [AW+1:0]   addr_r;
  logic [31:0]     wdata_r;
  logic            signed_r;
  logic [4:0]      rd_r;
  logic            resp_valid_r;
  logic [4:0]      resp_rd_r;
  logic [31:0]     resp_data_r;
  logic            err_r;
  logic [31:0]     mem_r [DEPTH_WORDS];

  logic [AW-1:0]   idx_s;
  logic [3:0]      mask_s;
  logic [31:0]     wword_s;
  logic [31:0]     rword_s;
  logic [31:0]     ldata_s;
  logic            misalign_s;
  logic            last_busy_s;
  logic            load_ok_s;
  logic            store_ok_s;
  logic            halt_s;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Right-aligned store data replicated so every candidate lane sees it.
  function automatic logic [31:0] store_word(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign idx_s       = addr_r[AW+1:2];
  assign mask_s      = lane_mask(size_r, addr_r[1:0]);
  assign wword_s     = store_word(size_r, wdata_r);
  assign rword_s     = mem_r[idx_s];
  assign ldata_s     = load_extend(rword_s, size_r, addr_r[1:0], signed_r);
  assign last_busy_s = (state_r == ST_BUSY) && (cnt_r == {CW{1'b0}});
  assign load_ok_s   = !we_r && !misalign_s;
  assign store_ok_s  = we_r && !misalign_s;

  // Alignment classification of the captured request.
  always_comb begin
    misalign_s = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    case (size_r)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = addr_r[0];
      default: misalign_s = (addr_r[1:0] != 2'b00);
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // Stall is combinational so upstream freezes in the very cycle a request is accepted.
  always_comb begin
    halt_s = 1'b0;
    if (state_r == ST_BUSY) begin
      halt_s = 1'b1;
    end else if (state_r == ST_IDLE) begin
      halt_s = bus.req_valid;
    end else begin
      halt_s = 1'b0;
    end
  end

  // Memory array: not reset; a store commits only in its last BUSY cycle.
  always_ff @(posedge clk) begin
    if (!reset && last_busy_s && store_ok_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
        end
      end
    end
  end

  // Access FSM with request capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      we_r         <= 1'b0;
      size_r       <= 2'b00;
      addr_r       <= '0;
      wdata_r      <= 32'h0000_0000;
      signed_r     <= 1'b0;
      rd_r         <= 5'd0;
      resp_valid_r <= 1'b0;
      resp_rd_r    <= 5'd0;
      resp_data_r  <= 32'h0000_0000;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_r     <= bus.req_we;
            size_r   <= bus.req_size;
            addr_r   <= bus.req_addr[AW+1:0];
            wdata_r  <= bus.req_wdata;
            signed_r <= bus.req_signed;
            rd_r     <= bus.req_rd;
            cnt_r    <= CNT_LOAD;
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r      <= ST_RESP;
            resp_valid_r <= load_ok_s;
            resp_rd_r    <= load_ok_s ? rd_r : 5'd0;
            resp_data_r  <= load_ok_s ? ldata_s : 32'h0000_0000;
            err_r        <= misalign_s;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_RESP: begin
          // The completed request is still presented here; it must not restart.
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          resp_rd_r    <= 5'd0;
          resp_data_r  <= 32'h0000_0000;
          err_r        <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= {CW{1'b0}};
          resp_valid_r <= 1'b0;
          resp_rd_r    <= 5'd0;
          resp_data_r  <= 32'h0000_0000;
          err_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.halt       = halt_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rd    = resp_rd_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.err        = err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam int NS    = LAT + 2;

  logic clk = 1'b0;
  logic reset;
  dmem_responder_if bus_if ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] mem_m [DEPTH];
  logic        obs_halt [NS];
  logic        obs_rv   [NS];
  logic [4:0]  obs_rd   [NS];
  logic [31:0] obs_data [NS];
  logic        obs_err  [NS];

  function automatic logic ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return (addr[1:0] != 2'd0);
    return 1'b0;
`else
    return (size == 2'd0) && (addr == 32'd0) && 1'b0;
`endif
  endfunction

  task automatic ref_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic sgn, output logic [31:0] exp);
    int idx, off, nb, base;
    logic [31:0] w, v;
    exp = 32'd0;
    if (ref_misaligned(size, addr)) return;
    idx  = int'((addr / 32'd4) % DEPTH);
    off  = int'(addr % 32'd4);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = (off / nb) * nb;
    w    = mem_m[idx];
    if (we) begin
      for (int i = 0; i < nb; i++) w[8*(base+i) +: 8] = wdata[8*i +: 8];
      mem_m[idx] = w;
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(base+i) +: 8];
      if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      exp = v;
    end
  endtask

  // Called at a negedge; presents the request for NS cycles and records outputs.
  task automatic drive_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic sgn, input logic [4:0] rd);
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = we;
    bus_if.req_size   = size;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    bus_if.req_signed = sgn;
    bus_if.req_rd     = rd;
    for (int k = 0; k < NS; k++) begin
      #1;
      obs_halt[k] = bus_if.halt;
      obs_rv[k]   = bus_if.resp_valid;
      obs_rd[k]   = bus_if.resp_rd;
      obs_data[k] = bus_if.resp_data;
      obs_err[k]  = bus_if.err;
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go_idle();
    repeat (3) @(negedge clk);
    checks_total++;
    if (bus_if.halt !== 1'b0) $display("FAIL reset_halt got %b want 0", bus_if.halt); else checks_passed++;
    checks_total++;
    if (bus_if.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus_if.resp_valid); else checks_passed++;
    checks_total++;
    if (bus_if.resp_rd !== 5'd0) $display("FAIL reset_resp_rd got %0d want 0", bus_if.resp_rd); else checks_passed++;
    checks_total++;
    if (bus_if.resp_data !== 32'd0) $display("FAIL reset_resp_data got %h want 0", bus_if.resp_data); else checks_passed++;
    checks_total++;
    if (bus_if.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus_if.err); else checks_passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init();
    logic [31:0] d, e;
    for (int w = 0; w < DEPTH; w++) begin
      d = $urandom;
      drive_req(1'b1, 2'd2, 32'(w * 4), d, 1'b0, 5'd0);
      ref_access(1'b1, 2'd2, 32'(w * 4), d, 1'b0, e);
    end
    go_idle();
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] e, d;
    int hc, rc;
    drive_req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 5'd1);
    ref_access(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, e);
    hc = 0; rc = 0;
    for (int k = 0; k < NS; k++) begin hc += int'(obs_halt[k]); rc += int'(obs_rv[k]); end
    checks_total++;
    if (hc != LAT + 1 || rc != 0) $display("FAIL store_word_halt halt=%0d rv=%0d want %0d/0", hc, rc, LAT + 1); else checks_passed++;
    drive_req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 5'd2);
    hc = 0; rc = 0;
    for (int k = 0; k < NS; k++) begin hc += int'(obs_halt[k]); rc += int'(obs_rv[k]); end
    checks_total++;
    if (hc != LAT + 1 || rc != 1) $display("FAIL load_word_strobes halt=%0d rv=%0d want %0d/1", hc, rc, LAT + 1); else checks_passed++;
    checks_total++;
    if (obs_data[LAT+1] !== 32'hDEADBEEF) $display("FAIL load_word_data got %h want deadbeef", obs_data[LAT+1]); else checks_passed++;

    drive_req(1'b1, 2'd2, 32'h10, 32'h0, 1'b0, 5'd0);
    ref_access(1'b1, 2'd2, 32'h10, 32'h0, 1'b0, e);
    drive_req(1'b1, 2'd0, 32'h13, 32'h80, 1'b0, 5'd0);
    ref_access(1'b1, 2'd0, 32'h13, 32'h80, 1'b0, e);
    drive_req(1'b0, 2'd0, 32'h13, 32'h0, 1'b1, 5'd4);
    checks_total++;
    if (obs_data[LAT+1] !== 32'hFFFFFF80) $display("FAIL load_byte_signed got %h want ffffff80", obs_data[LAT+1]); else checks_passed++;
    drive_req(1'b0, 2'd0, 32'h13, 32'h0, 1'b0, 5'd4);
    checks_total++;
    if (obs_data[LAT+1] !== 32'h00000080) $display("FAIL load_byte_unsigned got %h want 00000080", obs_data[LAT+1]); else checks_passed++;

    d = $urandom;
    drive_req(1'b1, 2'd2, 32'h400, d, 1'b0, 5'd0);
    ref_access(1'b1, 2'd2, 32'h400, d, 1'b0, e);
    drive_req(1'b0, 2'd2, 32'h000, 32'h0, 1'b0, 5'd5);
    checks_total++;
    if (obs_data[LAT+1] !== d) $display("FAIL wrap_load got %h want %h", obs_data[LAT+1], d); else checks_passed++;

    drive_req(1'b0, 2'd2, 32'h002, 32'h0, 1'b0, 5'd6);
`ifdef DMEM_ALIGN_CHECK_EN
    checks_total++;
    if (obs_err[LAT+1] !== 1'b1 || obs_rv[LAT+1] !== 1'b0)
      $display("FAIL misaligned_word err=%b rv=%b want 1/0", obs_err[LAT+1], obs_rv[LAT+1]); else checks_passed++;
`else
    checks_total++;
    if (obs_rv[LAT+1] !== 1'b1 || obs_data[LAT+1] !== d || obs_err[LAT+1] !== 1'b0)
      $display("FAIL unaligned_word rv=%b data=%h err=%b want 1/%h/0", obs_rv[LAT+1], obs_data[LAT+1], obs_err[LAT+1], d); else checks_passed++;
`endif
    go_idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, eb;
    int rc;
    ref_access(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, ea);
    ref_access(1'b0, 2'd1, 32'h46, 32'h0, 1'b1, eb);
    drive_req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 5'd7);
    rc = 0;
    for (int k = 0; k < NS; k++) rc += int'(obs_rv[k]);
    checks_total++;
    if (rc != 1 || obs_rd[LAT+1] !== 5'd7 || obs_data[LAT+1] !== ea)
      $display("FAIL b2b_first rv_count=%0d rd=%0d data=%h want 1/7/%h", rc, obs_rd[LAT+1], obs_data[LAT+1], ea); else checks_passed++;
    drive_req(1'b0, 2'd1, 32'h46, 32'h0, 1'b1, 5'd9);
    checks_total++;
    if (obs_halt[0] !== 1'b1 || obs_halt[1] !== 1'b1) $display("FAIL b2b_accept halt=%b%b want 11", obs_halt[0], obs_halt[1]); else checks_passed++;
    checks_total++;
    if (obs_rv[LAT+1] !== 1'b1 || obs_rd[LAT+1] !== 5'd9 || obs_data[LAT+1] !== eb)
      $display("FAIL b2b_second rv=%b rd=%0d data=%h want 1/9/%h", obs_rv[LAT+1], obs_rd[LAT+1], obs_data[LAT+1], eb); else checks_passed++;
    go_idle();
    #1;
    checks_total++;
    if (bus_if.halt !== 1'b0 || bus_if.resp_valid !== 1'b0) $display("FAIL b2b_idle halt=%b rv=%b want 0/0", bus_if.halt, bus_if.resp_valid); else checks_passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic we, sgn, mis, lv;
    logic [1:0] size;
    logic [31:0] addr, wdata, e;
    logic [4:0] rd;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = $urandom; rd = 5'($urandom_range(0, 31));
      mis = ref_misaligned(size, addr);
      lv = !we && !mis;
      ref_access(we, size, addr, wdata, sgn, e);
      drive_req(we, size, addr, wdata, sgn, rd);
      for (int k = 0; k < NS; k++) begin
        checks_total++;
        if (obs_halt[k] !== (k <= LAT)) $display("FAIL rnd_halt n=%0d k=%0d got %b want %b", n, k, obs_halt[k], (k <= LAT)); else checks_passed++;
        checks_total++;
        if (obs_rv[k] !== (k == LAT + 1 && lv)) $display("FAIL rnd_resp_valid n=%0d k=%0d got %b", n, k, obs_rv[k]); else checks_passed++;
        checks_total++;
        if (obs_err[k] !== (k == LAT + 1 && mis)) $display("FAIL rnd_err n=%0d k=%0d got %b", n, k, obs_err[k]); else checks_passed++;
        if (k != LAT + 1) begin
          checks_total++;
          if (obs_rd[k] !== 5'd0 || obs_data[k] !== 32'd0) $display("FAIL rnd_quiet n=%0d k=%0d rd=%0d data=%h want 0", n, k, obs_rd[k], obs_data[k]); else checks_passed++;
        end else if (lv) begin
          checks_total++;
          if (obs_rd[k] !== rd || obs_data[k] !== e)
            $display("FAIL rnd_load n=%0d addr=%h size=%0d got rd=%0d data=%h want %0d/%h", n, addr, size, obs_rd[k], obs_data[k], rd, e); else checks_passed++;
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        go_idle();
        #1;
        checks_total++;
        if (bus_if.halt !== 1'b0 || bus_if.resp_valid !== 1'b0) $display("FAIL rnd_idle n=%0d halt=%b rv=%b", n, bus_if.halt, bus_if.resp_valid); else checks_passed++;
        @(negedge clk);
      end
    end
    go_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    logic [31:0] prior;
    prior = mem_m[8];
    bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_size = 2'd2;
    bus_if.req_addr = 32'h20; bus_if.req_wdata = ~prior; bus_if.req_signed = 1'b0; bus_if.req_rd = 5'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    go_idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks_total++;
    if (bus_if.halt !== 1'b0 || bus_if.err !== 1'b0) $display("FAIL rst_busy_idle halt=%b err=%b want 0/0", bus_if.halt, bus_if.err); else checks_passed++;
    @(negedge clk);
    for (int k = 0; k < LAT + 2; k++) begin
      #1;
      checks_total++;
      if (bus_if.resp_valid !== 1'b0 || bus_if.halt !== 1'b0) $display("FAIL rst_busy_no_resp k=%0d rv=%b halt=%b", k, bus_if.resp_valid, bus_if.halt); else checks_passed++;
      @(negedge clk);
    end
    drive_req(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, 5'd3);
    checks_total++;
    if (obs_rv[LAT+1] !== 1'b1 || obs_data[LAT+1] !== prior) $display("FAIL rst_busy_prior rv=%b got %h want %h", obs_rv[LAT+1], obs_data[LAT+1], prior); else checks_passed++;
    go_idle();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_size   = 2'd0;
    bus_if.req_addr   = 32'd0;
    bus_if.req_wdata  = 32'd0;
    bus_if.req_signed = 1'b0;
    bus_if.req_rd     = 5'd0;
    @(negedge clk);
    test_reset();
    test_init();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_busy();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 256, number of 32-bit words in internal data memory; power of two, >=4.
REQ-002 Parameter LATENCY, 3, number of BUSY cycles per access; integer >=1.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  memory request from the memory-access pipeline stage.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 req_addr  input  32  byte address, little-endian.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_signed  input  1  load sign-extension select.
REQ-011 req_rd  input  5  load destination register.
REQ-012 halt  output  1  pipeline stall to upstream stage registers; combinational.
REQ-013 resp_valid  output  1  one-cycle load-result strobe to the writeback stage.
REQ-014 resp_rd  output  5  load destination register.
REQ-015 resp_data  output  32  extended load data.
REQ-016 err  output  1  misaligned-access strobe (see Configuration).

Function
REQ-017 FSM states IDLE, BUSY, RESP SHALL be used; IDLE->BUSY on req_valid in IDLE; BUSY->RESP when latency counter is 0; RESP->IDLE unconditionally.
REQ-018 On IDLE with req_valid, request fields SHALL be captured and the counter loaded with LATENCY-1.
REQ-019 In BUSY the counter SHALL decrement each cycle; BUSY lasts exactly LATENCY cycles.
REQ-020 halt SHALL equal (IDLE and req_valid) or BUSY; halt SHALL be 0 in RESP.
REQ-021 For a request accepted in cycle T: halt high T..T+LATENCY, RESP at T+LATENCY+1.
REQ-022 req_valid in RESP SHALL be ignored (upstream still presents the completed request); a new request is accepted no earlier than the following IDLE cycle.
REQ-023 Stores SHALL write memory in the last BUSY cycle, updating only selected byte lanes: byte lane addr[1:0], halfword lanes {addr[1],0}+0/1, word all four.
REQ-024 Memory read for loads SHALL occur in the last BUSY cycle; resp_data registered into RESP.
REQ-025 Loads SHALL assert resp_valid for exactly the RESP cycle with resp_rd = captured req_rd; stores SHALL never assert resp_valid.
REQ-026 Byte/halfword loads SHALL sign-extend when req_signed=1, else zero-extend; word loads unmodified.
REQ-027 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-028 resp_valid, resp_rd, resp_data, err SHALL be 0 outside RESP.

Reset
REQ-029 reset SHALL force IDLE, counter 0, halt 0 (absent req_valid), resp_valid 0, resp_rd 0, resp_data 0, err 0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 reset asserted during BUSY SHALL abandon the access; a store not yet written SHALL not be committed, and no response SHALL follow.

Configuration
REQ-032 Macro DMEM_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL perform no memory access, pulse err=1 in RESP, keep resp_valid=0; timing unchanged.
REQ-033 DMEM_ALIGN_CHECK_EN undefined: err tied 0; halfword ignores addr[0], word ignores addr[1:0].

Verification
REQ-034 LATENCY=3, store word 0xDEADBEEF @0x10 then load word @0x10 -> halt high 4 cycles each, resp_valid one cycle, resp_data 0xDEADBEEF.
REQ-035 Store byte 0x80 @0x13 over 0x00000000, load byte signed @0x13 -> resp_data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Load with req_rd=7 held through RESP -> exactly one resp_valid, resp_rd=7; back-to-back request accepted cycle after RESP.
REQ-037 DEPTH_WORDS=256, store @0x400 then load @0x000 -> same word (wrap).
REQ-038 reset in second BUSY cycle of a store to 0x20 -> IDLE next cycle, later load @0x20 returns prior contents.
REQ-039 With DMEM_ALIGN_CHECK_EN, load word @0x02 -> err=1 one cycle, resp_valid=0; without it, resp_data = word @0x00.
